gpo_pad_ctrl: RTL and testbench



---
 rtl/gpo_pad_ctrl_pkg.sv | 39 +++
 rtl/gpo_pad_ctrl_cnt.sv | 27 ++
 rtl/gpo_pad_ctrl.sv | 151 +++++++++++++++
 tb/tb_gpo_pad_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpo_pad_ctrl_pkg.sv
// Shared types and helpers for the GPO pad sequencer.
package gpo_pad_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OE_OFF,
    SETTLE,
    APPLY,
    BIAS_WAIT,
    OE_ON
  } state_t;

  localparam logic [1:0] MODE_PP  = 2'b00;
  localparam logic [1:0] MODE_OD  = 2'b01;
  localparam logic [1:0] MODE_OS  = 2'b10;
  localparam logic [1:0] MODE_HIZ = 2'b11;

  typedef struct packed {
    logic [3:0] ds;
    logic       sr;
    logic       co;
    logic [1:0] odmode;
    logic       oe;
  } pad_cfg_t;

  // Returns {odp, odn} for the requested output mode.
  function automatic logic [1:0] odmode_decode(input logic [1:0] odmode);
    logic [1:0] od;
    od = 2'b00;
    case (odmode)
      MODE_PP:  od = 2'b00;
      MODE_OD:  od = 2'b10;
      MODE_OS:  od = 2'b01;
      MODE_HIZ: od = 2'b11;
    endcase
    return od;
  endfunction

endpackage

// File: rtl/gpo_pad_ctrl_cnt.sv
// Loadable down-counter with zero flag; reused for the settle and VBIAS timeout windows.
module gpo_pad_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gpo_pad_ctrl.sv
// Per-pad sequencer: applies new 1.8 V GPO pad settings with OE dropped around the change.
//
// state     | meaning
// IDLE      | waiting for a config request, ready high
// OE_OFF    | drop pad OE before touching config
// SETTLE    | hold OE low for SETTLE_CYCLES
// APPLY     | drive shadow config onto the pad
// BIAS_WAIT | high drive selected, wait for VBIAS or time out
// OE_ON     | re-enable pad output
module gpo_pad_ctrl
  import gpo_pad_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int BIAS_TIMEOUT  = 64,
  parameter int CNT_W         = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_valid_i,
  output logic       cfg_ready_o,
  input  logic [3:0] cfg_ds_i,
  input  logic       cfg_sr_i,
  input  logic       cfg_co_i,
  input  logic [1:0] cfg_odmode_i,
  input  logic       cfg_oe_i,
  input  logic       data_i,
  input  logic       vbias_ok_i,
  output logic       busy_o,
  output logic       err_o,
  output logic       pad_do_o,
  output logic [3:0] pad_ds_o,
  output logic       pad_sr_o,
  output logic       pad_co_o,
  output logic       pad_oe_o,
  output logic       pad_odp_o,
  output logic       pad_odn_o
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIAS_LOAD   = CNT_W'(BIAS_TIMEOUT - 1);

  state_t           state;
  pad_cfg_t         shadow;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  // Counter is loaded on the single-cycle state that precedes each timed window.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = SETTLE_LOAD;
    case (state)
      OE_OFF:    cnt_load = 1'b1;
      APPLY: begin
        cnt_load = 1'b1;
        cnt_val  = BIAS_LOAD;
      end
      SETTLE, BIAS_WAIT: cnt_dec = 1'b1;
      default: ;
    endcase
  end

  gpo_pad_ctrl_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) pad_do_o <= 1'b0;
    else       pad_do_o <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      shadow      <= '0;
      cfg_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      pad_ds_o    <= '0;
      pad_sr_o    <= 1'b0;
      pad_co_o    <= 1'b0;
      pad_oe_o    <= 1'b0;
      pad_odp_o   <= 1'b0;
      pad_odn_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid_i) begin
            shadow      <= pad_cfg_t'{ds: cfg_ds_i, sr: cfg_sr_i, co: cfg_co_i,
                                      odmode: cfg_odmode_i, oe: cfg_oe_i};
            err_o       <= 1'b0;
            cfg_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= pad_oe_o ? OE_OFF : APPLY;
          end
        end
        OE_OFF: begin
          pad_oe_o <= 1'b0;
          state    <= SETTLE;
        end
        SETTLE: begin
          if (cnt_zero) state <= APPLY;
        end
        APPLY: begin
          pad_ds_o               <= shadow.ds;
          pad_sr_o               <= shadow.sr;
          pad_co_o               <= shadow.co;
          {pad_odp_o, pad_odn_o} <= odmode_decode(shadow.odmode);
          if (!shadow.oe) begin
            state       <= IDLE;
            cfg_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else if (shadow.ds[1:0] == 2'b00) begin
            state <= OE_ON;
          end else begin
            state <= BIAS_WAIT;
          end
        end
        BIAS_WAIT: begin
          // A VBIAS-ok on the final cycle still wins over the timeout.
          if (vbias_ok_i) begin
            state <= OE_ON;
          end else if (cnt_zero) begin
            err_o         <= 1'b1;
            pad_ds_o[1:0] <= 2'b00;
            state         <= OE_ON;
          end
        end
        OE_ON: begin
          pad_oe_o    <= 1'b1;
          state       <= IDLE;
          cfg_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          cfg_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpo_pad_ctrl.sv
// Bench for gpo_pad_ctrl: each request is turned into an event timeline, checked cycle by cycle.
module tb_gpo_pad_ctrl;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_ds;
  logic       cfg_sr;
  logic       cfg_co;
  logic [1:0] cfg_odmode;
  logic       cfg_oe;
  logic       data_i;
  logic       vbias;
  logic       busy;
  logic       err;
  logic       pad_do;
  logic [3:0] pad_ds;
  logic       pad_sr;
  logic       pad_co;
  logic       pad_oe;
  logic       pad_odp;
  logic       pad_odn;

  int checks = 0;
  int errors = 0;

  // Pad state as seen from outside once a request has completed.
  logic [3:0] m_ds;
  logic       m_sr, m_co, m_odp, m_odn, m_oe, m_err;

  always #5 clk = ~clk;

  gpo_pad_ctrl #(.SETTLE_CYCLES(SETTLE), .BIAS_TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_ds_i     (cfg_ds),
    .cfg_sr_i     (cfg_sr),
    .cfg_co_i     (cfg_co),
    .cfg_odmode_i (cfg_odmode),
    .cfg_oe_i     (cfg_oe),
    .data_i       (data_i),
    .vbias_ok_i   (vbias),
    .busy_o       (busy),
    .err_o        (err),
    .pad_do_o     (pad_do),
    .pad_ds_o     (pad_ds),
    .pad_sr_o     (pad_sr),
    .pad_co_o     (pad_co),
    .pad_oe_o     (pad_oe),
    .pad_odp_o    (pad_odp),
    .pad_odn_o    (pad_odn)
  );

  // Mode table: push-pull, open-drain (P side), open-source (N side), hi-Z hold (both).
  function automatic logic [1:0] od_pins(input logic [1:0] mode);
    logic [1:0] r;
    case (mode)
      2'd0:    r = 2'b00;
      2'd1:    r = 2'b10;
      2'd2:    r = 2'b01;
      default: r = 2'b11;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string ph, input logic [3:0] e_ds, input logic e_sr,
                           input logic e_co, input logic e_odp, input logic e_odn,
                           input logic e_oe, input logic e_busy, input logic e_ready,
                           input logic e_err, input logic e_do);
    chk4({ph, ".ds"},    pad_ds,    e_ds);
    chk1({ph, ".sr"},    pad_sr,    e_sr);
    chk1({ph, ".co"},    pad_co,    e_co);
    chk1({ph, ".odp"},   pad_odp,   e_odp);
    chk1({ph, ".odn"},   pad_odn,   e_odn);
    chk1({ph, ".oe"},    pad_oe,    e_oe);
    chk1({ph, ".busy"},  busy,      e_busy);
    chk1({ph, ".ready"}, cfg_ready, e_ready);
    chk1({ph, ".err"},   err,       e_err);
    chk1({ph, ".do"},    pad_do,    e_do);
  endtask

  task automatic noise_cfg();
    cfg_ds     = 4'($urandom);
    cfg_sr     = 1'($urandom);
    cfg_co     = 1'($urandom);
    cfg_odmode = 2'($urandom);
    cfg_oe     = 1'($urandom);
  endtask

  task automatic model_reset();
    m_ds = 4'h0; m_sr = 1'b0; m_co = 1'b0; m_odp = 1'b0; m_odn = 1'b0;
    m_oe = 1'b0; m_err = 1'b0;
  endtask

  task automatic idle(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b0;
      noise_cfg();
      vbias  = 1'($urandom);
      data_i = 1'($urandom);
      tick();
      check_out(nm, m_ds, m_sr, m_co, m_odp, m_odn, m_oe, 1'b0, 1'b1, m_err, data_i);
    end
  endtask

  // vb_d < 0: VBIAS never arrives; otherwise it is sampled high vb_d+1 edges after APPLY.
  task automatic run_req(input string nm, input logic [3:0] ds, input logic sr, input logic co,
                         input logic [1:0] mode, input logic oe, input int vb_d);
    int         t_apply, t_on, t_to, t_end;
    logic [3:0] e_ds;
    logic [1:0] od;
    logic       nc;
    t_apply = m_oe ? SETTLE + 2 : 1;
    t_on    = -1;
    t_to    = -1;
    if (oe) begin
      if (ds[1:0] == 2'b00)                    t_on = t_apply + 1;
      else if (vb_d >= 0 && vb_d < TIMEOUT)    t_on = t_apply + 2 + vb_d;
      else begin
        t_to = t_apply + TIMEOUT;
        t_on = t_to + 1;
      end
      t_end = t_on;
    end else begin
      t_end = t_apply;
    end
    od = od_pins(mode);

    cfg_valid = 1'b1; cfg_ds = ds; cfg_sr = sr; cfg_co = co; cfg_odmode = mode; cfg_oe = oe;
    vbias  = 1'($urandom);
    data_i = 1'($urandom);
    tick();
    cfg_valid = 1'($urandom);
    noise_cfg();
    vbias  = 1'($urandom);
    data_i = 1'($urandom);
    for (int k = 1; k <= t_end; k++) begin
      tick();
      nc   = (k >= t_apply);
      e_ds = nc ? ds : m_ds;
      if (t_to >= 0 && k >= t_to) e_ds[1:0] = 2'b00;
      check_out(nm, e_ds, nc ? sr : m_sr, nc ? co : m_co, nc ? od[1] : m_odp,
                nc ? od[0] : m_odn, (t_on >= 0 && k >= t_on), (k < t_end), (k == t_end),
                (t_to >= 0 && k >= t_to), data_i);
      if (k < t_end) begin
        cfg_valid = 1'($urandom);
        noise_cfg();
      end else begin
        cfg_valid = 1'b0;
      end
      if (k < t_apply) vbias = 1'($urandom);
      else             vbias = (vb_d >= 0 && k >= t_apply + vb_d && k < t_end);
      data_i = 1'($urandom);
    end
    m_ds  = (t_to >= 0) ? {ds[3:2], 2'b00} : ds;
    m_sr  = sr;
    m_co  = co;
    m_odp = od[1];
    m_odn = od[0];
    m_oe  = oe;
    m_err = (t_to >= 0);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ds = 4'h0; cfg_sr = 1'b0; cfg_co = 1'b0;
    cfg_odmode = 2'b00; cfg_oe = 1'b0; vbias = 1'b0; data_i = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("reset", 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    end
    rst = 1'b0;
    idle("post_reset", 3);

    run_req("sr_oe_from_off", 4'b0000, 1'b1, 1'b0, 2'b00, 1'b1, -1);
    idle("idle_a", 2);
    run_req("ds1100_from_on", 4'b1100, 1'b0, 1'b1, 2'b01, 1'b1, -1);
    run_req("vbias_after10", 4'b0011, 1'b1, 1'b1, 2'b10, 1'b1, 9);
    run_req("bias_timeout", 4'b0011, 1'b0, 1'b0, 2'b11, 1'b1, -1);
    idle("err_sticky", 3);
    run_req("clear_err_oe0", 4'b0101, 1'b1, 1'b0, 2'b01, 1'b0, -1);
    run_req("vbias_last", 4'b1010, 1'b0, 1'b1, 2'b00, 1'b1, TIMEOUT - 1);
    run_req("vbias_first", 4'b0110, 1'b1, 1'b0, 2'b10, 1'b1, 0);

    for (int i = 0; i < 24; i++) begin
      int r, vd;
      r = int'($urandom_range(0, 3));
      case (r)
        0:       vd = -1;
        1:       vd = int'($urandom_range(0, 5));
        2:       vd = int'($urandom_range(0, TIMEOUT + 3));
        default: vd = TIMEOUT - 1;
      endcase
      run_req("rand", 4'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
              ($urandom_range(0, 3) != 0), vd);
      idle("rand_idle", int'($urandom_range(0, 2)));
    end

    // Reset in the middle of the settle window.
    run_req("pre_rst", 4'b1000, 1'b1, 1'b1, 2'b11, 1'b1, -1);
    cfg_valid = 1'b1; cfg_ds = 4'b0111; cfg_sr = 1'b0; cfg_co = 1'b0;
    cfg_odmode = 2'b01; cfg_oe = 1'b1; data_i = 1'b0;
    tick();
    cfg_valid = 1'b0;
    tick();
    chk1("mid.oe_off", pad_oe, 1'b0);
    chk1("mid.busy", busy, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    data_i = 1'b1;
    tick();
    check_out("rst_settle", 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    rst = 1'b0;
    model_reset();
    idle("do_follow", 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
